// File: rtl/dcf77_encoder_pkg.sv
// Shared types and constants for the DCF77 time-code encoder.
// Bit positions follow the over-the-air frame layout, LSB of each field first.
package dcf77_encoder_pkg;

  typedef logic [3:0] bcd_t;

  localparam int unsigned DCF77_FRAME_BITS = 59;

  localparam int unsigned DCF77_BIT_CALL   = 15;
  localparam int unsigned DCF77_BIT_DST    = 16;
  localparam int unsigned DCF77_BIT_Z1     = 17;
  localparam int unsigned DCF77_BIT_Z2     = 18;
  localparam int unsigned DCF77_BIT_LEAP   = 19;
  localparam int unsigned DCF77_BIT_START  = 20;
  localparam int unsigned DCF77_BIT_MIN    = 21;
  localparam int unsigned DCF77_BIT_P1     = 28;
  localparam int unsigned DCF77_BIT_HOUR   = 29;
  localparam int unsigned DCF77_BIT_P2     = 35;
  localparam int unsigned DCF77_BIT_DAY    = 36;
  localparam int unsigned DCF77_BIT_DOW    = 42;
  localparam int unsigned DCF77_BIT_MONTH  = 45;
  localparam int unsigned DCF77_BIT_YEAR   = 50;
  localparam int unsigned DCF77_BIT_P3     = 58;
  localparam int unsigned DCF77_BIT_MARKER = 59;

  localparam int unsigned DCF77_TICKS_PER_SEC = 100;
  localparam int unsigned DCF77_PULSE0_TICKS  = 10;
  localparam int unsigned DCF77_PULSE1_TICKS  = 20;

endpackage

// File: rtl/dcf77_encoder_if.sv
// Time-field inputs, strobes and transmit outputs of the DCF77 encoder.
// master drives the time fields and strobes; slave is the encoder.
interface dcf77_encoder_if;
  import dcf77_encoder_pkg::*;

  logic            clk_en;
  logic            enable;
  bcd_t [1:0]      year;
  bcd_t [1:0]      month;
  bcd_t [1:0]      day;
  logic [2:0]      day_of_week;
  bcd_t [1:0]      hour;
  bcd_t [1:0]      minute;
  logic            cest;
  logic            announce_dst;
  logic            announce_leap;
  logic            call_bit;
  logic            tx;
  logic [5:0]      second_idx;
  logic            frame_start;
  logic            bit_value;

  modport master (
    output clk_en, enable, year, month, day, day_of_week, hour, minute,
           cest, announce_dst, announce_leap, call_bit,
    input  tx, second_idx, frame_start, bit_value
  );

  modport slave (
    input  clk_en, enable, year, month, day, day_of_week, hour, minute,
           cest, announce_dst, announce_leap, call_bit,
    output tx, second_idx, frame_start, bit_value
  );

endinterface

// File: rtl/dcf77_frame_builder.sv
// Combinational mapping of BCD time fields and flags onto the 59-bit DCF77 frame.
// Out-of-range digits are encoded unchanged; surplus tens bits are dropped.
module dcf77_frame_builder
  import dcf77_encoder_pkg::*;
(
  input  bcd_t [1:0]                  year,
  input  bcd_t [1:0]                  month,
  input  bcd_t [1:0]                  day,
  input  logic [2:0]                  day_of_week,
  input  bcd_t [1:0]                  hour,
  input  bcd_t [1:0]                  minute,
  input  logic                        cest,
  input  logic                        announce_dst,
  input  logic                        announce_leap,
  input  logic                        call_bit,
  output logic [DCF77_FRAME_BITS-1:0] frame
);

  logic unused_tens;
  assign unused_tens = ^{month[1][3:1], day[1][3:2], hour[1][3:2], minute[1][3]};

  always_comb begin
    frame = '0;
    frame[DCF77_BIT_CALL]  = call_bit;
    frame[DCF77_BIT_DST]   = announce_dst;
    frame[DCF77_BIT_Z1]    = cest;
    frame[DCF77_BIT_Z2]    = ~cest;
    frame[DCF77_BIT_LEAP]  = announce_leap;
    frame[DCF77_BIT_START] = 1'b1;

    frame[DCF77_BIT_MIN +: 4]     = minute[0];
    frame[DCF77_BIT_MIN + 4 +: 3] = minute[1][2:0];
    frame[DCF77_BIT_P1]           = ^{minute[1][2:0], minute[0]};

    frame[DCF77_BIT_HOUR +: 4]     = hour[0];
    frame[DCF77_BIT_HOUR + 4 +: 2] = hour[1][1:0];
    frame[DCF77_BIT_P2]            = ^{hour[1][1:0], hour[0]};

    frame[DCF77_BIT_DAY +: 4]      = day[0];
    frame[DCF77_BIT_DAY + 4 +: 2]  = day[1][1:0];
    frame[DCF77_BIT_DOW +: 3]      = day_of_week;
    frame[DCF77_BIT_MONTH +: 4]    = month[0];
    frame[DCF77_BIT_MONTH + 4]     = month[1][0];
    frame[DCF77_BIT_YEAR +: 4]     = year[0];
    frame[DCF77_BIT_YEAR + 4 +: 4] = year[1];
    // Date parity spans day, weekday, month and year together.
    frame[DCF77_BIT_P3] = ^{day[1][1:0], day[0], day_of_week, month[1][0], month[0],
                            year[1], year[0]};
  end

endmodule

// File: rtl/dcf77_encoder.sv
// DCF77 amplitude-modulation time-code generator: one bit per second, 59-bit frame per
// minute with the missing pulse at second 59 as the minute marker.
module dcf77_encoder
  import dcf77_encoder_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = DCF77_TICKS_PER_SEC,
  parameter int unsigned PULSE0_TICKS  = DCF77_PULSE0_TICKS,
  parameter int unsigned PULSE1_TICKS  = DCF77_PULSE1_TICKS
) (
  input  logic           clk,
  input  logic           rst,
  dcf77_encoder_if.slave bus
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TickW-1:0] TickLast  = TickW'(TICKS_PER_SEC - 1);
  localparam logic [TickW-1:0] Len0      = TickW'(PULSE0_TICKS);
  localparam logic [TickW-1:0] Len1      = TickW'(PULSE1_TICKS);
  localparam logic [5:0]       SecMarker = 6'(DCF77_BIT_MARKER);

  logic [TickW-1:0]            tick_q, tick_d;
  logic [5:0]                  sec_q, sec_d;
  logic [DCF77_FRAME_BITS-1:0] frame_q, frame_d, frame_new;
  logic                        tx_q, tx_d;
  logic                        fs_q, fs_d;
  logic                        bv_q, bv_d;
  logic [DCF77_FRAME_BITS:0]   frame_pad;
  logic                        cur_bit;

  dcf77_frame_builder u_frame_builder (
    .year          (bus.year),
    .month         (bus.month),
    .day           (bus.day),
    .day_of_week   (bus.day_of_week),
    .hour          (bus.hour),
    .minute        (bus.minute),
    .cest          (bus.cest),
    .announce_dst  (bus.announce_dst),
    .announce_leap (bus.announce_leap),
    .call_bit      (bus.call_bit),
    .frame         (frame_new)
  );

  always_comb begin
    tick_d    = tick_q;
    sec_d     = sec_q;
    frame_d   = frame_q;
    tx_d      = tx_q;
    fs_d      = 1'b0;
    bv_d      = bv_q;
    frame_pad = '0;
    cur_bit   = 1'b0;

    if (!bus.enable) begin
      tick_d = '0;
      sec_d  = SecMarker;
      tx_d   = 1'b0;
      bv_d   = 1'b0;
    end else if (bus.clk_en) begin
      if (tick_q == TickLast) begin
        tick_d = '0;
        if (sec_q == SecMarker) begin
          sec_d   = '0;
          frame_d = frame_new;
          fs_d    = 1'b1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
      // Padding bit at the marker position reads as 0, so no pulse and bit_value=0 there.
      frame_pad = {1'b0, frame_d};
      cur_bit   = frame_pad[sec_d];
      tx_d      = (sec_d != SecMarker) && (tick_d < (cur_bit ? Len1 : Len0));
      bv_d      = cur_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      sec_q   <= SecMarker;
      frame_q <= '0;
      tx_q    <= 1'b0;
      fs_q    <= 1'b0;
      bv_q    <= 1'b0;
    end else begin
      tick_q  <= tick_d;
      sec_q   <= sec_d;
      frame_q <= frame_d;
      tx_q    <= tx_d;
      fs_q    <= fs_d;
      bv_q    <= bv_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.second_idx  = sec_q;
  assign bus.frame_start = fs_q;
  assign bus.bit_value   = bv_q;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Self-checking bench for dcf77_encoder: table-driven frames, random frame content and
// enable-drop sequences, all checked against an arithmetic model of the time code.
module tb_dcf77_encoder;
  import dcf77_encoder_pkg::*;

  typedef struct {
    int         yr, mo, dy, dw, hr, mi;
    bit         cest, dst, leap, call;
    logic [6:0] e_min;
    bit         e_p1;
    logic [5:0] e_hr;
    bit         e_p2;
    logic [5:0] e_day;
    logic [2:0] e_dow;
    logic [4:0] e_mon;
    logic [7:0] e_yr;
    bit         e_p3;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcf77_encoder_if bus ();

  dcf77_encoder #(
    .TICKS_PER_SEC (100),
    .PULSE0_TICKS  (10),
    .PULSE1_TICKS  (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: k = clk_en ticks since enable; the encoder starts 100 ticks before bit 0.
  int          k = 0;
  bit          en_model = 0;
  logic [58:0] mframe = '0;
  logic [58:0] obs;
  int          last_fs_k = -1;
  int          cur_yr, cur_mo, cur_dy, cur_dw, cur_hr, cur_mi;
  bit          cur_cest, cur_dst, cur_leap, cur_call;
  vec_t        vecs[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (k=%0d, t=%0t)", nm, act, exp, k, $time);
    end
  endtask

  // Greedy decomposition against the BCD weights gives the LSB-first field bits.
  function automatic void put(inout logic [58:0] f, input int v, input int pos, input int n);
    int w[8] = '{1, 2, 4, 8, 10, 20, 40, 80};
    for (int i = n - 1; i >= 0; i--) begin
      if (v >= w[i]) begin
        f[pos+i] = 1'b1;
        v -= w[i];
      end
    end
  endfunction

  function automatic bit even_par(input logic [58:0] f, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) c += int'(f[i]);
    return bit'(c % 2);
  endfunction

  function automatic logic [58:0] build_ref();
    logic [58:0] f = '0;
    f[15] = cur_call;
    f[16] = cur_dst;
    f[17] = cur_cest;
    f[18] = !cur_cest;
    f[19] = cur_leap;
    f[20] = 1'b1;
    put(f, cur_mi, 21, 7);
    put(f, cur_hr, 29, 6);
    put(f, cur_dy, 36, 6);
    put(f, cur_dw, 42, 3);
    put(f, cur_mo, 45, 5);
    put(f, cur_yr, 50, 8);
    f[28] = even_par(f, 21, 27);
    f[35] = even_par(f, 29, 34);
    f[58] = even_par(f, 36, 57);
    return f;
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic set_time(input int yr, input int mo, input int dy, input int dw, input int hr,
                          input int mi, input bit cest, input bit dst, input bit leap,
                          input bit call);
    cur_yr = yr; cur_mo = mo; cur_dy = dy; cur_dw = dw; cur_hr = hr; cur_mi = mi;
    cur_cest = cest; cur_dst = dst; cur_leap = leap; cur_call = call;
    bus.year          = to_bcd(yr);
    bus.month         = to_bcd(mo);
    bus.day           = to_bcd(dy);
    bus.day_of_week   = 3'(dw);
    bus.hour          = to_bcd(hr);
    bus.minute        = to_bcd(mi);
    bus.cest          = cest;
    bus.announce_dst  = dst;
    bus.announce_leap = leap;
    bus.call_bit      = call;
  endtask

  task automatic set_vec(input vec_t v);
    set_time(v.yr, v.mo, v.dy, v.dw, v.hr, v.mi, v.cest, v.dst, v.leap, v.call);
  endtask

  task automatic check_out(input bit exp_fs);
    int p, s, t, bv, etx;
    if (en_model) begin
      p   = (5900 + k) % 6000;
      s   = p / 100;
      t   = p % 100;
      bv  = (s == 59) ? 0 : int'(mframe[s]);
      etx = (s != 59 && t < (bv != 0 ? 20 : 10)) ? 1 : 0;
    end else begin
      s = 59; bv = 0; etx = 0;
    end
    chk("tx", bus.tx, etx);
    chk("second_idx", bus.second_idx, s);
    chk("bit_value", bus.bit_value, bv);
    chk("frame_start", bus.frame_start, exp_fs);
  endtask

  task automatic step(input bit en, input bit ce);
    bit exp_fs = 0;
    int p;
    @(negedge clk);
    bus.enable = en;
    bus.clk_en = ce;
    @(posedge clk);
    #1;
    if (!en || rst) begin
      en_model = 0;
      k = 0;
    end else begin
      en_model = 1;
      if (ce) begin
        k++;
        p = (5900 + k) % 6000;
        if (p == 0) begin
          mframe = build_ref();
          exp_fs = 1;
        end
        if (p % 100 == 0 && p / 100 < 59) obs[p/100] = bus.bit_value;
      end
    end
    check_out(exp_fs);
    if (en && ce && bus.frame_start === 1'b1) begin
      if (last_fs_k < 0) chk("fs_first_k", k, 100);
      else chk("fs_period", k - last_fs_k, 6000);
      last_fs_k = k;
    end
  endtask

  task automatic tick();
    repeat ($urandom_range(2, 1)) step(1, 0);
    step(1, 1);
  endtask

  task automatic run_to(input int target);
    while (k < target) tick();
  endtask

  initial begin
    vecs[0] = '{yr: 24, mo: 2, dy: 29, dw: 4, hr: 13, mi: 45,
                cest: 1, dst: 0, leap: 0, call: 0,
                e_min: 7'b1000101, e_p1: 1, e_hr: 6'b010011, e_p2: 1,
                e_day: 6'b101001, e_dow: 3'b100, e_mon: 5'b00010, e_yr: 8'b00100100, e_p3: 1};
    vecs[1] = '{yr: 24, mo: 2, dy: 29, dw: 4, hr: 13, mi: 46,
                cest: 1, dst: 0, leap: 0, call: 0,
                e_min: 7'b1000110, e_p1: 1, e_hr: 6'b010011, e_p2: 1,
                e_day: 6'b101001, e_dow: 3'b100, e_mon: 5'b00010, e_yr: 8'b00100100, e_p3: 1};
    vecs[2] = '{yr: 99, mo: 12, dy: 31, dw: 5, hr: 23, mi: 59,
                cest: 0, dst: 0, leap: 0, call: 1,
                e_min: 7'b1011001, e_p1: 0, e_hr: 6'b100011, e_p2: 1,
                e_day: 6'b110001, e_dow: 3'b101, e_mon: 5'b10010, e_yr: 8'b10011001, e_p3: 1};

    rst = 1'b1;
    bus.enable = 1'b0;
    bus.clk_en = 1'b0;
    set_time(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1);
    step(1, 1);
    rst = 1'b0;
    step(0, 1);

    set_vec(vecs[0]);
    for (int v = 0; v < 3; v++) begin
      obs = '0;
      // Mid-frame input change must only show up in the following frame.
      run_to(100 + 6000 * v + 3000);
      if (v < 2) set_vec(vecs[v+1]);
      else set_time($urandom_range(99, 0), $urandom_range(12, 1), $urandom_range(31, 1),
                    $urandom_range(7, 1), $urandom_range(23, 0), $urandom_range(59, 0),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      run_to(100 + 6000 * (v + 1) - 1);
      chk($sformatf("v%0d_bits0_14", v), obs[14:0], 0);
      chk($sformatf("v%0d_flags", v), obs[20:15],
          {1'b1, vecs[v].leap, !vecs[v].cest, vecs[v].cest, vecs[v].dst, vecs[v].call});
      chk($sformatf("v%0d_min", v), obs[27:21], vecs[v].e_min);
      chk($sformatf("v%0d_p1", v), obs[28], vecs[v].e_p1);
      chk($sformatf("v%0d_hour", v), obs[34:29], vecs[v].e_hr);
      chk($sformatf("v%0d_p2", v), obs[35], vecs[v].e_p2);
      chk($sformatf("v%0d_day", v), obs[41:36], vecs[v].e_day);
      chk($sformatf("v%0d_dow", v), obs[44:42], vecs[v].e_dow);
      chk($sformatf("v%0d_month", v), obs[49:45], vecs[v].e_mon);
      chk($sformatf("v%0d_year", v), obs[57:50], vecs[v].e_yr);
      chk($sformatf("v%0d_p3", v), obs[58], vecs[v].e_p3);
    end

    // Random frame runs to second 25 tick 5, inside a pulse, then enable drops.
    run_to(18100 + 2505);
    chk("pre_drop_tx", bus.tx, 1);
    step(0, 0);
    chk("drop_tx", bus.tx, 0);
    chk("drop_sec", bus.second_idx, 59);
    repeat (5) step(0, 1);

    last_fs_k = -1;
    step(1, 0);
    run_to(115);
    chk("reenable_fs_seen", last_fs_k, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcf77_encoder.md
Name: dcf77_encoder

Overview:
- Generates a DCF77-format amplitude-modulation time code from BCD time fields.
- Produces one bit per second and one 59-second frame per minute, with a missing pulse at second 59 as the minute marker.
- Sits beside the clock block and drives the receiver input for loopback self-test, or drives an external carrier modulator.
- Runs on clk (24 MHz), gated by the shared 10 ms clk_en strobe.

Parameters:
TICKS_PER_SEC, 100, clk_en ticks per second
PULSE0_TICKS, 10, reduction length for a 0 bit (100 ms)
PULSE1_TICKS, 20, reduction length for a 1 bit (200 ms)

Ports:
clk  in  1  clock, 24 MHz
rst  in  1  reset; rst is synchronous, active-high; clock clk
clk_en  in  1  10 ms tick strobe, one clk wide
enable  in  1  transmit enable, sampled every clk
year  in  2x bcd_t  frame year 00-99
month  in  2x bcd_t  frame month 01-12
day  in  2x bcd_t  frame day 01-31
day_of_week  in  3  1=Mon..7=Sun
hour  in  2x bcd_t  frame hour 00-23
minute  in  2x bcd_t  frame minute 00-59
cest, announce_dst, announce_leap, call_bit  in  1 each  flag bits 17, 16, 19, 15
tx  out  1  1 = carrier reduced
second_idx  out  6  current bit index 0-59
frame_start  out  1  one-clk pulse at start of bit 0
bit_value  out  1  value of the bit currently being sent

Behaviour:
- Reset values: tx=0, frame_start=0, bit_value=0, second_idx=59, tick counter=0, frame register=0.
- Idle:
  - Whenever enable=0, the next clk edge forces tx=0, second_idx=59, tick=0, frame_start=0, regardless of clk_en.
  - The frame register is held.
- Advance:
  - With enable=1 and clk_en=1, tick increments.
  - At tick=TICKS_PER_SEC-1, tick wraps to 0 and second_idx increments.
  - 59 wraps to 0.
  - No activity on clk edges without clk_en.
- Output timing:
  - tx is registered and updates on the same edge as the counters, computed from the new (second_idx, tick).
  - tx = (second_idx != 59) && (tick < len), where len = PULSE1_TICKS if frame[second_idx] else PULSE0_TICKS.
  - bit_value = frame[second_idx], forced to 0 at second 59.
- First frame after enable:
  - The block starts at second 59, so the first 100 ticks are a full gap (minute marker).
  - The first rising tx edge is 100 clk_en ticks after enable.
- Frame latch:
  - On the clk_en edge where second_idx goes 59→0, all time and flag inputs are latched into the 59-bit frame register.
  - frame_start pulses high for that single clk.
  - Inputs must describe the time valid at the next minute marker; upstream supplies minute+1.
  - Input changes mid-frame have no effect.
- Frame layout (BCD, LSB first):
  - bit 0 = 0; bits 1-14 = 0.
  - 15 call_bit; 16 announce_dst; 17 cest (Z1); 18 !cest (Z2); 19 announce_leap; 20 = 1.
  - 21-27 minute (1,2,4,8,10,20,40); 28 P1.
  - 29-34 hour (1,2,4,8,10,20); 35 P2.
  - 36-41 day (1,2,4,8,10,20); 42-44 day_of_week (1,2,4).
  - 45-49 month (1,2,4,8,10); 50-57 year (1,2,4,8,10,20,40,80); 58 P3.
  - Unused high BCD tens bits are dropped.
- Parity: P1, P2 and P3 are even parity, i.e. the XOR of 21-27, 29-34 and 36-57 respectively.
- No BCD validity checks; out-of-range digits are encoded as-is.
- No leap-second (61-bit) frames.
- Reset or enable drop mid-pulse: tx falls on the next clk edge; no partial pulse completion.

Decomposition:
- Shared types package:
  - bcd_t (already present).
  - Bit-position constants: DCF77_BIT_START=20, DCF77_BIT_P1=28, DCF77_BIT_P2=35, DCF77_BIT_P3=58, DCF77_BIT_MARKER=59.
  - Pulse-tick defaults.
- One sub-module, dcf77_frame_builder: purely combinational; maps the inputs to a 59-bit frame vector including parity.
- dcf77_encoder holds the counters, frame register and tx logic.

Test Plan:
- Reset, then enable=1 → tx=0 for 100 ticks, frame_start after tick 99, second_idx=0; bit 0 gives a 10-tick tx pulse.
- Time 24-02-29 Thu(4) 13:45, cest=1 → bits 21-27 = 1010001, P1=1; bits 29-34 = 110010, P2=1; bit 17=1, 18=0, 20=1. Each 1 gives a 20-tick pulse, each 0 a 10-tick pulse.
- Full frame → second 59 has tx=0 for all 100 ticks; the next frame_start occurs exactly 6000 ticks after the previous one.
- Change minute input at second 30 → the current frame is unchanged; the new value appears only in the next frame.
- Drop enable at second 25, tick 5, while tx=1 → tx=0 and second_idx=59 on the next clk. Re-enable → a full 100-tick gap before bit 0.
- Loopback into the team's DCF77 receiver and clock at 99-12-31 23:59 → the receiver syncs and its decoded fields match the transmitted fields after two frames.
